// File: rtl/axi_read_responder.sv
// axi_read_responder: pops one AR entry at a time from the 2-deep address
// queue. It walks the burst beat by beat through a synchronous word memory
// and returns every beat on the AXI3 R channel.
module axi_read_responder #(
   parameter int TAGBITS = 2,
   parameter int MEM_AW  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [48+TAGBITS:0]   aq_entry,
   input  logic                  aq_empty,
   output logic                  aq_pop,
   output logic                  mem_en,
   output logic [MEM_AW-1:0]     mem_addr,
   input  logic [31:0]           mem_rdata,
   output logic [TAGBITS-1:0]    rid,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  busy
);
   localparam int EW = 49 + TAGBITS;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, SEND = 2'd3} state_t;

   // Queue head fields. lock/cache/prot are deliberately ignored, so
   // exclusive accesses simply return OKAY.
   logic [TAGBITS-1:0] e_id;
   logic [31:0]        e_addr;
   logic [3:0]         e_len;
   logic [1:0]         e_size;
   logic [1:0]         e_burst;
   logic               unused_attr;

   assign e_id        = aq_entry[EW-1:49];
   assign e_addr      = aq_entry[48:17];
   assign e_len       = aq_entry[16:13];
   assign e_size      = aq_entry[12:11];
   assign e_burst     = aq_entry[10:9];
   assign unused_attr = ^aq_entry[8:0];

   state_t             state_q, state_d;
   logic [TAGBITS-1:0] id_q, id_d;
   logic [31:0]        addr_q, addr_d;
   logic [3:0]         len_q, len_d;
   logic [1:0]         size_q, size_d;
   logic [1:0]         mode_q, mode_d;
   logic               slverr_q, slverr_d;
   logic [3:0]         beat_q, beat_d;
   logic [TAGBITS-1:0] rid_q, rid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [1:0]         rresp_q, rresp_d;
   logic               rlast_q, rlast_d;

   logic               decerr;
   logic               beat_ok;

   function automatic logic wrap_len_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

   // A burst is SLVERR as a whole when it is unsupported in shape.
   function automatic logic slverr_class(input logic [3:0] len, input logic [1:0] size,
                                         input logic [1:0] burst);
      return (size == 2'd3) || (burst == 2'b11) ||
             ((burst == BURST_WRAP) && !wrap_len_ok(len));
   endfunction

   // Effective addressing mode. A malformed WRAP or a reserved burst type
   // steps like INCR. Its data never reaches the memory anyway.
   function automatic logic [1:0] addr_mode(input logic [3:0] len, input logic [1:0] burst);
      if (burst == BURST_FIXED) return BURST_FIXED;
      if ((burst == BURST_WRAP) && wrap_len_ok(len)) return BURST_WRAP;
      return BURST_INCR;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [1:0] size, input logic [1:0] mode);
      logic [31:0] inc;
      logic [31:0] mask;
      inc  = 32'd1 << size;
      mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      case (mode)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + inc) & mask);
         default:     next_addr = addr + inc;
      endcase
   endfunction

   // Decode is checked per beat, because INCR can walk off the region mid-burst.
   assign decerr  = |addr_q[31:MEM_AW+2];
   assign beat_ok = !slverr_q && !decerr;

   // Next-state, capture and per-state strobes for the beat sequencer.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      size_d   = size_q;
      mode_d   = mode_q;
      slverr_d = slverr_q;
      beat_d   = beat_q;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rlast_d  = rlast_q;
      aq_pop   = 1'b0;
      mem_en   = 1'b0;
      case (state_q)
         IDLE: begin
            // The pop is gated by reset so that a non-empty queue is not
            // drained while the block is held in reset.
            if (!aq_empty && rst) begin
               aq_pop   = 1'b1;
               id_d     = e_id;
               addr_d   = e_addr;
               len_d    = e_len;
               size_d   = e_size;
               mode_d   = addr_mode(e_len, e_burst);
               slverr_d = slverr_class(e_len, e_size, e_burst);
               beat_d   = 4'd0;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            mem_en  = beat_ok;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            rdata_d = beat_ok ? mem_rdata : 32'd0;
            rresp_d = slverr_q ? RESP_SLVERR : (decerr ? RESP_DECERR : RESP_OKAY);
            rid_d   = id_q;
            rlast_d = (beat_q == len_q);
            state_d = SEND;
         end
         SEND: begin
            if (rready) begin
               if (rlast_q) begin
                  state_d = IDLE;
               end else begin
                  beat_d  = beat_q + 4'd1;
                  addr_d  = next_addr(addr_q, len_q, size_q, mode_q);
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         mode_q   <= BURST_FIXED;
         slverr_q <= 1'b0;
         beat_q   <= '0;
         rid_q    <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         mode_q   <= mode_d;
         slverr_q <= slverr_d;
         beat_q   <= beat_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         rlast_q  <= rlast_d;
      end
   end

   assign mem_addr = addr_q[MEM_AW+1:2];
   assign rid      = rid_q;
   assign rdata    = rdata_q;
   assign rresp    = rresp_q;
   assign rlast    = rlast_q;
   assign rvalid   = (state_q == SEND);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder. A queue model feeds AR entries and a
// synchronous memory model answers reads. A burst-level reference model
// predicts every beat and memory address, and a negedge monitor compares
// the DUT against it.
module tb_axi_read_responder;
   localparam int TAGBITS = 2;
   localparam int MEM_AW  = 10;
   localparam int EW      = 49 + TAGBITS;

   logic                clk = 1'b0;
   logic                rst;
   logic [EW-1:0]       aq_entry;
   logic                aq_empty;
   logic                aq_pop;
   logic                mem_en;
   logic [MEM_AW-1:0]   mem_addr;
   logic [31:0]         mem_rdata = '0;
   logic [TAGBITS-1:0]  rid;
   logic [31:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   logic                busy;

   always #5 clk = ~clk;

   axi_read_responder #(.TAGBITS(TAGBITS), .MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst), .aq_entry(aq_entry), .aq_empty(aq_empty), .aq_pop(aq_pop),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready), .busy(busy)
   );

   typedef struct {
      logic [TAGBITS-1:0] id;
      logic [31:0]        data;
      logic [1:0]         resp;
      logic               last;
   } beat_t;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   mem [0:(1<<MEM_AW)-1];
   logic [EW-1:0] tbq[$];
   beat_t         exp_q[$];
   int            exp_ma[$];
   beat_t         act_q[$];
   int            act_ma[$];
   int            lat_log[$];
   int            pops_seen = 0;
   int            pops_done = 0;
   int            rr_mode = 0;

   // Synchronous word memory: data appears the cycle after the strobe.
   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input int id, input logic [31:0] addr, input int len,
                                        input int size, input int burst);
      logic [TAGBITS-1:0] i;
      logic [3:0]         l;
      logic [1:0]         s;
      logic [1:0]         b;
      i = TAGBITS'(id);
      l = 4'(len);
      s = 2'(size);
      b = 2'(burst);
      return {i, addr, l, s, b, 2'(0), 4'(0), 3'(0)};
   endfunction

   // Reference model: expand one AR entry into its beats and memory reads.
   function automatic void expand(input logic [EW-1:0] e);
      logic [TAGBITS-1:0] id;
      logic [31:0]        a;
      logic [31:0]        bound;
      int                 ln;
      int                 sz;
      int                 bu;
      bit                 wrap_ok;
      bit                 slv;
      beat_t              bt;
      id      = e[EW-1:49];
      a       = e[48:17];
      ln      = int'(e[16:13]);
      sz      = int'(e[12:11]);
      bu      = int'(e[10:9]);
      wrap_ok = (ln == 1) || (ln == 3) || (ln == 7) || (ln == 15);
      slv     = (sz == 3) || (bu == 3) || (bu == 2 && !wrap_ok);
      for (int b = 0; b <= ln; b++) begin
         bt.id   = id;
         bt.last = (b == ln);
         if (slv)                       bt.resp = 2'd2;
         else if ((a >> (MEM_AW + 2)) != 0) bt.resp = 2'd3;
         else                           bt.resp = 2'd0;
         if (bt.resp == 2'd0) begin
            bt.data = mem[a[MEM_AW+1:2]];
            exp_ma.push_back(int'(a[MEM_AW+1:2]));
         end else begin
            bt.data = 32'd0;
         end
         exp_q.push_back(bt);
         if (bu == 0) begin
            a = a;
         end else if (bu == 2 && wrap_ok) begin
            bound = 32'(ln + 1) << sz;
            a = (a & ~(bound - 1)) | ((a + (32'd1 << sz)) & (bound - 1));
         end else begin
            a = a + (32'd1 << sz);
         end
      end
   endfunction

   // Compare process: samples everything on the falling edge.
   int    cyc = 0;
   int    ref_cyc = 0;
   bit    ref_ok = 0;
   logic  prev_rv = 1'b0;
   logic  prev_rr = 1'b0;
   beat_t prev_b;
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      cyc++;
      cur.id = rid; cur.data = rdata; cur.resp = rresp; cur.last = rlast;
      if (!rst) begin
         exp_q.delete();
         exp_ma.delete();
         ref_ok  = 0;
         prev_rv = 1'b0;
         prev_rr = 1'b0;
      end else begin
         if (aq_pop) begin
            chk("pop_nonempty", 64'(aq_empty), 64'(0));
            chk("pop_after_last", 64'(exp_q.size()), 64'(0));
            if (tbq.size() > 0) expand(tbq[0]);
            pops_seen++;
            ref_cyc = cyc;
            ref_ok  = 1;
         end
         if (mem_en) begin
            if (exp_ma.size() == 0) chk("mem_en_unexpected", 64'(1), 64'(0));
            else chk("mem_addr", 64'(mem_addr), 64'(exp_ma.pop_front()));
            act_ma.push_back(int'(mem_addr));
         end
         if (rvalid && !prev_rv && ref_ok) begin
            chk("rvalid_latency", 64'(cyc - ref_cyc), 64'(3));
            lat_log.push_back(cyc - ref_cyc);
            ref_ok = 0;
         end
         if (prev_rv && !prev_rr) begin
            chk("hold_rvalid", 64'(rvalid), 64'(1));
            chk("hold_beat", {30'(0), rid, rdata, rresp, rlast},
                {30'(0), prev_b.id, prev_b.data, prev_b.resp, prev_b.last});
         end
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("rid", 64'(rid), 64'(e.id));
               chk("rdata", 64'(rdata), 64'(e.data));
               chk("rresp", 64'(rresp), 64'(e.resp));
               chk("rlast", 64'(rlast), 64'(e.last));
            end
            act_q.push_back(cur);
            ref_cyc = cyc;
            ref_ok  = !rlast;
         end
         prev_rv = rvalid;
         prev_rr = rready;
         prev_b  = cur;
      end
   end

   task automatic refresh();
      aq_empty = (tbq.size() == 0);
      aq_entry = aq_empty ? '0 : tbq[0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      while (pops_done < pops_seen) begin
         if (tbq.size() > 0) tbq.delete(0);
         pops_done++;
      end
      refresh();
      case (rr_mode)
         0:       rready = 1'b1;
         1:       rready = ($urandom_range(0, 3) != 0);
         default: rready = 1'b0;
      endcase
   endtask

   task automatic push(input logic [EW-1:0] e);
      tbq.push_back(e);
      refresh();
   endtask

   task automatic clear_logs();
      act_q.delete();
      act_ma.delete();
      lat_log.delete();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!(tbq.size() == 0 && exp_q.size() == 0 && !busy && pops_done == pops_seen)
             && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 64'(n < budget), 64'(1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n;
      logic [31:0] ra;
      for (int k = 0; k < (1 << MEM_AW); k++) mem[k] = 32'hA0 + 32'(k);
      rst = 1'b1; rready = 1'b0; aq_empty = 1'b1; aq_entry = '0;
      #2 rst = 1'b0;
      tick(); tick();

      // Reset values.
      chk("rst_ctrl", 64'({aq_pop, mem_en, rvalid, rlast, busy}), 64'(0));
      chk("rst_beat", 64'({rid, rdata, rresp}), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      rst = 1'b1;
      tick();

      // INCR, four beats from word 4.
      rr_mode = 0; clear_logs(); p0 = pops_seen;
      push(mk(1, 32'h10, 3, 2, 1));
      wait_done(200);
      chk("t1_beats", 64'(act_q.size()), 64'(4));
      chk("t1_pops", 64'(pops_seen - p0), 64'(1));
      if (act_q.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk("t1_rdata", 64'(act_q[i].data), 64'(32'hA4 + 32'(i)));
            chk("t1_resp_id_last", 64'({act_q[i].resp, act_q[i].id, act_q[i].last}),
                64'({2'd0, 2'd1, (i == 3)}));
         end
      chk("t1_latency", 64'(lat_log.size() > 0 ? lat_log[0] : -1), 64'(3));

      // WRAP within a 16-byte window.
      clear_logs();
      push(mk(0, 32'h38, 3, 2, 2));
      wait_done(200);
      chk("t2_count", 64'(act_ma.size()), 64'(4));
      if (act_ma.size() == 4) begin
         chk("t2_ma0", 64'(act_ma[0]), 64'h0E);
         chk("t2_ma1", 64'(act_ma[1]), 64'h0F);
         chk("t2_ma2", 64'(act_ma[2]), 64'h0C);
         chk("t2_ma3", 64'(act_ma[3]), 64'h0D);
      end

      // FIXED re-reads one word.
      clear_logs();
      push(mk(1, 32'h8, 2, 2, 0));
      wait_done(200);
      chk("t3a_count", 64'(act_ma.size()), 64'(3));
      for (int i = 0; i < act_ma.size(); i++) chk("t3a_ma", 64'(act_ma[i]), 64'h2);
      if (act_q.size() == 3) chk("t3a_rdata", 64'(act_q[2].data), 64'hA2);

      // size=3 is SLVERR for every beat with no memory access.
      clear_logs();
      push(mk(2, 32'h0, 1, 3, 1));
      wait_done(200);
      chk("t3b_beats", 64'(act_q.size()), 64'(2));
      chk("t3b_mem_en", 64'(act_ma.size()), 64'(0));
      for (int i = 0; i < act_q.size(); i++)
         chk("t3b_resp_data", 64'({act_q[i].resp, act_q[i].data}), 64'({2'd2, 32'd0}));

      // INCR crossing the top of the decoded region.
      clear_logs();
      push(mk(3, 32'hFFC, 1, 2, 1));
      wait_done(200);
      chk("t4_beats", 64'(act_q.size()), 64'(2));
      if (act_q.size() == 2) begin
         chk("t4_b1", 64'({act_q[0].resp, act_q[0].data}), 64'({2'd0, 32'h49F}));
         chk("t4_b2", 64'({act_q[1].resp, act_q[1].data}), 64'({2'd3, 32'd0}));
      end

      // Backpressure: rready low while the beat waits.
      clear_logs();
      rr_mode = 2;
      push(mk(1, 32'h20, 0, 2, 1));
      repeat (8) tick();
      chk("t5a_rvalid", 64'(rvalid), 64'(1));
      chk("t5a_beat", 64'({rdata, rlast}), 64'({32'hA8, 1'b1}));
      rr_mode = 0;
      wait_done(200);

      // Two queued entries are served strictly in order.
      clear_logs(); p0 = pops_seen;
      rr_mode = 1;
      push(mk(2, 32'h0, 1, 2, 1));
      push(mk(3, 32'h40, 1, 2, 1));
      wait_done(400);
      chk("t5b_pops", 64'(pops_seen - p0), 64'(2));
      chk("t5b_beats", 64'(act_q.size()), 64'(4));
      if (act_q.size() == 4)
         chk("t5b_order", 64'({act_q[0].id, act_q[1].id, act_q[2].id, act_q[3].id}),
             64'({2'd2, 2'd2, 2'd3, 2'd3}));

      // Reset during beat 2 of an 8-beat burst.
      rr_mode = 0; clear_logs(); p0 = pops_seen;
      push(mk(1, 32'h0, 7, 2, 1));
      push(mk(2, 32'h100, 1, 2, 1));
      n = 0;
      while (act_q.size() < 1 && n < 200) begin tick(); n++; end
      chk("t6_first_beat", 64'(act_q.size()), 64'(1));
      tick(); tick();
      chk("t6_pre_rvalid", 64'(rvalid), 64'(1));
      rst = 1'b0;
      #1;
      chk("t6_rst_rvalid_busy", 64'({rvalid, busy}), 64'(0));
      tick(); tick();
      clear_logs();
      rst = 1'b1;
      wait_done(200);
      chk("t6_pops", 64'(pops_seen - p0), 64'(2));
      chk("t6_beats", 64'(act_q.size()), 64'(2));
      if (act_q.size() == 2) begin
         chk("t6_b0", 64'({act_q[0].id, act_q[0].data}), 64'({2'd2, 32'hE0}));
         chk("t6_b1", 64'({act_q[1].id, act_q[1].data}), 64'({2'd2, 32'hE1}));
      end

      // Randomized traffic against the reference model.
      rr_mode = 1;
      for (int t = 0; t < 250; t++) begin
         int sel;
         n = 0;
         while (tbq.size() >= 2 && n < 2000) begin tick(); n++; end
         chk("rand_space", 64'(n < 2000), 64'(1));
         sel = $urandom_range(0, 9);
         if (sel < 6)      ra = 32'($urandom_range(0, 32'hFFF));
         else if (sel < 8) ra = 32'hFC0 + 32'($urandom_range(0, 63));
         else              ra = $urandom;
         push({TAGBITS'($urandom), ra, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 9'($urandom)});
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_done(5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- Target-side consumer of the 2-entry read-address queue: pops one queued AR entry at a time, generates per-beat addresses, reads a synchronous word memory and drives the AXI3 R channel.
- Sits between the AR address FIFO output and the target memory macro.
- Returns RID, RDATA, RRESP and RLAST with RVALID/RREADY handshaking.

Parameters:
TAGBITS, 2, ID width; entry width is 49+TAGBITS bits.
MEM_AW, 10, memory word-address width; decoded region is byte addresses 0 to 2^(MEM_AW+2)-1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
aq_entry  in  49+TAGBITS  queue head; combinational, valid whenever aq_empty=0. Packing MSB to LSB: id, addr[31:0], len[3:0], size[1:0], burst[1:0], lock[1:0], cache[3:0], prot[2:0].
aq_empty  in  1  queue empty flag
aq_pop  out  1  queue read enable, one-cycle pulse
mem_en  out  1  memory read strobe
mem_addr  out  MEM_AW  word address (addr[MEM_AW+1:2])
mem_rdata  in  32  read data, valid the cycle after mem_en
rid  out  TAGBITS  response ID
rdata  out  32  read data
rresp  out  2  0=OKAY, 2=SLVERR, 3=DECERR
rlast  out  1  final beat of burst
rvalid  out  1  R channel valid
rready  in  1  R channel ready
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset: state IDLE; aq_pop, mem_en, rvalid, rlast, busy = 0; rid, rdata, rresp, mem_addr = 0; internal address and beat counter = 0.
- FSM states: IDLE, ISSUE, CAPTURE, SEND.
- IDLE, aq_empty=0:
  - aq_pop=1 for that cycle; capture id, addr, len, size, burst from aq_entry in the same edge.
  - beat_cnt=0; compute the burst error class; go to ISSUE.
- IDLE, aq_empty=1: stay in IDLE.
- ISSUE: mem_en=1 only if the beat is OKAY class, else mem_en=0; go to CAPTURE.
- CAPTURE:
  - rdata <= mem_rdata (OKAY class) or 0 (error class).
  - rresp, rid, and rlast = (beat_cnt==len) registered.
  - Go to SEND.
- SEND: rvalid=1; rid, rdata, rresp, rlast held stable until rready.
  - On rvalid and rready: if rlast, go to IDLE.
  - Otherwise beat_cnt+1, advance address, go to ISSUE.
- Timing:
  - Pop at cycle T: mem_en at T+1, first rvalid at T+3.
  - Minimum 3 cycles per beat.
  - Next pop no earlier than the cycle after the last handshake.
- Address advance, inc = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr+inc, 32-bit wrap-around, no 4KB check.
  - WRAP (10): bound = (len+1)<<size; addr = (addr & ~(bound-1)) | ((addr+inc) & (bound-1)).
- Error classes, in priority order:
  - size=3 (8 bytes on a 32-bit bus): SLVERR for every beat.
  - burst=11: SLVERR.
  - WRAP with len not in {1,3,7,15}: SLVERR, addressed as INCR.
  - addr[31:MEM_AW+2] != 0 for the current beat: DECERR for that beat only; checked per beat.
- Error handling:
  - SLVERR bursts still produce len+1 beats with rdata=0 and never assert mem_en.
  - lock, cache, prot are ignored; exclusive accesses return OKAY.
- Narrow transfers return the full memory word; the initiator selects lanes.
- aq_pop is never asserted when aq_empty=1, and never outside IDLE.
- Reset mid-burst: burst aborted, remaining beats dropped, popped entry discarded; after reset release the next queue entry is serviced normally.

Test Plan:
1. Queue one INCR entry: id=1, addr=0x10, len=3, size=2. Memory word k = 0xA0+k. -> four beats, rdata 0xA4,0xA5,0xA6,0xA7, rresp=0, rid=1, rlast only on beat 4, single aq_pop pulse; with rready held 1, first rvalid 3 cycles after pop.
2. WRAP: addr=0x38, len=3, size=2. -> mem_addr sequence 0x0E,0x0F,0x0C,0x0D.
3. Error bursts:
   - FIXED addr=0x8, len=2 -> mem_addr 0x2 three times.
   - size=3, len=1 -> two beats, rresp=2, rdata=0, mem_en never high.
4. INCR starting one word below the region top with MEM_AW=10: addr=0xFFC, len=1. -> beat 1 OKAY, beat 2 (addr 0x1000) rresp=3.
5. Backpressure:
   - Hold rready=0 for 5 cycles in SEND -> rvalid, rdata, rlast stable.
   - Two queued entries (ids 2, 3) -> all beats of id 2 before id 3; second pop only after id 2's rlast handshake.
6. Assert rst low during beat 2 of a len=7 burst. -> rvalid=0 and busy=0 immediately; after release, the next queued entry starts at beat 0.
